// File: rtl/mmem_rd_addr_gen_pkg.sv
// mem_pckg: main-memory read-command types shared by the read address generator
package mem_pckg;
    localparam int C_MMEM_ADDR_WDT = 16;
    typedef enum logic [1:0] {PM_IDLE, PM_INTERN, PM_EXTERN} mem_port_mux_t;
    typedef enum logic [1:0] {DT_INT8, DT_INT16, DT_FP16, DT_FP32} data_type_t;
    typedef struct packed {
        logic                       cmd_rd_en;
        logic [C_MMEM_ADDR_WDT-1:0] cmd_rd_addr;
        mem_port_mux_t              cmd_rd_port_mux;
        data_type_t                 cmd_rd_data_vect_type;
        logic                       cmd_rd_data_vect_zero_padd;
        logic                       cmd_rd_data_vect_neg_inf_padd;
        logic                       cmd_rd_data_vect_last;
    } mem_cmd_rd_t;
    typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} rd_addr_gen_state_t;
endpackage

// File: rtl/mmem_rd_addr_gen_grid_cnt.sv
// grid_cnt: row-major 2-D position counter with wrap, exposing the next position
// so the caller can build a registered command for it in the same cycle.
module grid_cnt #(
    parameter int W = 13
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         clr,
    input  logic         load,
    input  logic         adv,
    input  logic [W-1:0] rows,
    input  logic [W-1:0] cols,
    output logic [W-1:0] nxt_row,
    output logic [W-1:0] nxt_col,
    output logic         last,
    output logic         nxt_last
);
    logic [W-1:0] row, col;
    logic         col_end, row_end;
    always_comb begin
        col_end  = col == cols - W'(1);
        row_end  = row == rows - W'(1);
        nxt_col  = col_end ? '0 : col + W'(1);
        nxt_row  = col_end ? (row_end ? '0 : row + W'(1)) : row;
        last     = col_end && row_end;
        nxt_last = nxt_row == rows - W'(1) && nxt_col == cols - W'(1);
    end
    always_ff @(posedge clk or posedge rst)
        if (rst) begin
            row <= '0;
            col <= '0;
        end else if (clr || load) begin
            row <= '0;
            col <= '0;
        end else if (adv) begin
            row <= nxt_row;
            col <= nxt_col;
        end
endmodule

// File: rtl/mmem_rd_addr_gen.sv
// mmem_rd_addr_gen: walks a padded feature map in row-major order and issues one
// main-memory read command per position, flagging border positions as padding.
module mmem_rd_addr_gen
    import mem_pckg::*;
#(
    parameter int DIM_WDT = 10,
    parameter int PAD_WDT = 2
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       en,
    input  logic                       clear,
    input  logic                       stall,
    input  logic                       start,
    output logic                       done,
    output logic                       busy,
    input  logic [C_MMEM_ADDR_WDT-1:0] cfg_base_addr,
    input  logic [DIM_WDT-1:0]         cfg_h,
    input  logic [DIM_WDT-1:0]         cfg_w,
    input  logic [PAD_WDT-1:0]         cfg_pad,
    input  logic                       cfg_pad_neg_inf,
    input  mem_port_mux_t              cfg_port_mux,
    input  data_type_t                 cfg_data_type,
    output mem_cmd_rd_t                rd_cmd
);
    localparam int PW = DIM_WDT + PAD_WDT + 1;
    localparam int AW = C_MMEM_ADDR_WDT;

    function automatic logic interior(input logic [PW-1:0] r, c, p, h, w);
        return r >= p && r < p + h && c >= p && c < p + w;
    endfunction

    function automatic mem_cmd_rd_t mk(input logic in_b, input logic [AW-1:0] a, input logic ni,
                                       input logic lst, input mem_port_mux_t m, input data_type_t d);
        mem_cmd_rd_t c;
        c = '0;
        c.cmd_rd_en = 1'b1;
        c.cmd_rd_addr = in_b ? a : '0;
        c.cmd_rd_port_mux = m;
        c.cmd_rd_data_vect_type = d;
        c.cmd_rd_data_vect_zero_padd = !in_b && !ni;
        c.cmd_rd_data_vect_neg_inf_padd = !in_b && ni;
        c.cmd_rd_data_vect_last = lst;
        return c;
    endfunction

    rd_addr_gen_state_t state;
    logic [PW-1:0]      h_r, w_r, pad_r, rows_r, cols_r;
    logic [AW-1:0]      addr_r;
    logic               neg_r, empty_r;
    mem_port_mux_t      mux_r;
    data_type_t         dt_r;
    logic [PW-1:0]      s_h, s_w, s_pad, s_rows, s_cols, nxt_row, nxt_col;
    logic               s_in, s_last, s_empty, n_in, go, adv, last, nxt_last;

    always_comb begin
        s_h     = PW'(cfg_h);
        s_w     = PW'(cfg_w);
        s_pad   = PW'(cfg_pad);
        s_rows  = s_h + s_pad + s_pad;
        s_cols  = s_w + s_pad + s_pad;
        s_empty = cfg_h == '0 || cfg_w == '0;
        s_in    = interior('0, '0, s_pad, s_h, s_w);
        s_last  = s_rows == PW'(1) && s_cols == PW'(1);
        n_in    = interior(nxt_row, nxt_col, pad_r, h_r, w_r);
        go      = en && !stall;
        adv     = state == S_RUN && !empty_r && go && !last;
    end

    grid_cnt #(.W(PW)) u_grid (
        .clk      (clk),
        .rst      (rst),
        .clr      (clear),
        .load     (state == S_IDLE && start && en),
        .adv      (adv),
        .rows     (rows_r),
        .cols     (cols_r),
        .nxt_row  (nxt_row),
        .nxt_col  (nxt_col),
        .last     (last),
        .nxt_last (nxt_last)
    );

    always_ff @(posedge clk or posedge rst)
        if (rst) begin
            state <= S_IDLE; rd_cmd <= '0; done <= 1'b0; busy <= 1'b0; addr_r <= '0; empty_r <= 1'b0;
            h_r <= '0; w_r <= '0; pad_r <= '0; rows_r <= '0; cols_r <= '0; neg_r <= 1'b0;
            mux_r <= PM_IDLE; dt_r <= DT_INT8;
        end else if (clear) begin
            state <= S_IDLE; rd_cmd <= '0; done <= 1'b0; busy <= 1'b0; addr_r <= '0; empty_r <= 1'b0;
            h_r <= '0; w_r <= '0; pad_r <= '0; rows_r <= '0; cols_r <= '0; neg_r <= 1'b0;
            mux_r <= PM_IDLE; dt_r <= DT_INT8;
        end else begin
            done <= 1'b0;
            case (state)
                S_IDLE: if (start && en) begin
                    state <= S_RUN; busy <= 1'b1; empty_r <= s_empty;
                    h_r <= s_h; w_r <= s_w; pad_r <= s_pad; rows_r <= s_rows; cols_r <= s_cols;
                    neg_r <= cfg_pad_neg_inf; mux_r <= cfg_port_mux; dt_r <= cfg_data_type;
                    rd_cmd <= s_empty ? '0 : mk(s_in, cfg_base_addr, cfg_pad_neg_inf, s_last, cfg_port_mux, cfg_data_type);
                    addr_r <= cfg_base_addr + AW'(s_in);
                end
                S_RUN: if (empty_r || (go && last)) begin
                    // Empty frames skip straight to DONE so done still lands two cycles after start.
                    state <= S_DONE; done <= 1'b1; rd_cmd <= '0;
                end else if (go) begin
                    rd_cmd <= mk(n_in, addr_r, neg_r, nxt_last, mux_r, dt_r);
                    addr_r <= addr_r + AW'(n_in);
                end
                default: begin
                    state <= S_IDLE; busy <= 1'b0;
                end
            endcase
        end
endmodule

// File: tb/tb_mmem_rd_addr_gen.sv
// tb_mmem_rd_addr_gen: directed frames with a command scoreboard built from an
// independent multiply-based address model.
module tb_mmem_rd_addr_gen;
    import mem_pckg::*;
    logic                       clk = 1'b0, rst = 1'b1, en = 1'b1, clear = 1'b0, stall = 1'b0, start = 1'b0;
    logic                       done, busy;
    logic [C_MMEM_ADDR_WDT-1:0] cfg_base_addr = '0;
    logic [9:0]                 cfg_h = '0, cfg_w = '0;
    logic [1:0]                 cfg_pad = '0;
    logic                       cfg_pad_neg_inf = 1'b0;
    mem_port_mux_t              cfg_port_mux = PM_INTERN;
    data_type_t                 cfg_data_type = DT_INT8;
    mem_cmd_rd_t                rd_cmd, exp_c;
    mem_cmd_rd_t                q[$];
    int n_chk = 0, n_fail = 0, n_cmd = 0, n_done = 0, cyc, base_cmd, base_done;

    mmem_rd_addr_gen #(.DIM_WDT(10), .PAD_WDT(2)) dut (
        .clk(clk), .rst(rst), .en(en), .clear(clear), .stall(stall), .start(start),
        .done(done), .busy(busy), .cfg_base_addr(cfg_base_addr), .cfg_h(cfg_h), .cfg_w(cfg_w),
        .cfg_pad(cfg_pad), .cfg_pad_neg_inf(cfg_pad_neg_inf), .cfg_port_mux(cfg_port_mux),
        .cfg_data_type(cfg_data_type), .rd_cmd(rd_cmd)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    always @(negedge clk) begin
        if (done) n_done++;
        if (!rst && rd_cmd.cmd_rd_en && en && !stall) begin
            n_cmd++;
            if (q.size() == 0) chk("unexpected_cmd", 64'(rd_cmd), 64'(0));
            else begin
                exp_c = q.pop_front();
                chk("cmd", 64'(rd_cmd), 64'(exp_c));
            end
        end
    end

    task automatic push_frame(input logic [15:0] b, input int h, input int w, input int p, input logic ni);
        mem_cmd_rd_t e;
        int rr, cc;
        rr = h + 2 * p;
        cc = w + 2 * p;
        if (h == 0 || w == 0) return;
        for (int r = 0; r < rr; r++)
            for (int c = 0; c < cc; c++) begin
                e = '0;
                e.cmd_rd_en = 1'b1;
                e.cmd_rd_port_mux = cfg_port_mux;
                e.cmd_rd_data_vect_type = cfg_data_type;
                if (r >= p && r < p + h && c >= p && c < p + w)
                    e.cmd_rd_addr = b + 16'((r - p) * w + (c - p));
                else begin
                    e.cmd_rd_data_vect_zero_padd = !ni;
                    e.cmd_rd_data_vect_neg_inf_padd = ni;
                end
                e.cmd_rd_data_vect_last = (r == rr - 1 && c == cc - 1);
                q.push_back(e);
            end
    endtask

    task automatic start_frame(input logic [15:0] b, input int h, input int w, input int p, input logic ni,
                               input mem_port_mux_t m, input data_type_t d);
        cfg_base_addr = b; cfg_h = 10'(h); cfg_w = 10'(w); cfg_pad = 2'(p);
        cfg_pad_neg_inf = ni; cfg_port_mux = m; cfg_data_type = d;
        push_frame(b, h, w, p, ni);
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic wait_done(output int n);
        n = 0;
        while (!done && n < 100) begin
            tick();
            n++;
        end
        chk("done_seen", 64'(done), 64'(1));
    endtask

    task automatic after_done();
        tick();
        chk("done_pulse_width", 64'(done), 64'(0));
        chk("busy_after_done", 64'(busy), 64'(0));
    endtask

    initial begin
        tick();
        tick();
        chk("reset_cmd", 64'(rd_cmd), 64'(0));
        chk("reset_busy", 64'(busy), 64'(0));
        chk("reset_done", 64'(done), 64'(0));
        rst = 1'b0;
        // basic frame, first start right after reset release
        start_frame(16'h0100, 2, 3, 0, 1'b0, PM_INTERN, DT_INT16);
        chk("first_latency_en", 64'(rd_cmd.cmd_rd_en), 64'(1));
        chk("first_latency_addr", 64'(rd_cmd.cmd_rd_addr), 64'h100);
        chk("busy_run", 64'(busy), 64'(1));
        wait_done(cyc);
        chk("basic_done_cycle", 64'(cyc), 64'(6));
        after_done();
        chk("idle_cmd", 64'(rd_cmd), 64'(0));
        // zero padding
        start_frame(16'h0040, 2, 2, 1, 1'b0, PM_EXTERN, DT_FP16);
        wait_done(cyc);
        chk("zpad_done_cycle", 64'(cyc), 64'(16));
        after_done();
        // neg-inf padding with a 3-cycle stall on command 4
        start_frame(16'h0040, 2, 2, 1, 1'b1, PM_INTERN, DT_FP32);
        for (int i = 0; i < 4; i++) tick();
        stall = 1'b1;
        for (int i = 0; i < 3; i++) begin
            chk("stall_hold", 64'(rd_cmd), 64'(q[0]));
            tick();
        end
        chk("stall_hold_end", 64'(rd_cmd), 64'(q[0]));
        stall = 1'b0;
        wait_done(cyc);
        chk("ninf_done_cycle", 64'(cyc), 64'(12));
        after_done();
        // address wrap
        start_frame(16'hFFFE, 1, 4, 0, 1'b0, PM_INTERN, DT_INT8);
        wait_done(cyc);
        chk("wrap_done_cycle", 64'(cyc), 64'(4));
        after_done();
        // asynchronous reset mid-frame
        base_done = n_done;
        start_frame(16'h0200, 2, 3, 0, 1'b0, PM_INTERN, DT_INT8);
        for (int i = 0; i < 3; i++) tick();
        #2 rst = 1'b1;
        #1;
        chk("async_rst_cmd", 64'(rd_cmd), 64'(0));
        chk("async_rst_busy", 64'(busy), 64'(0));
        q.delete();
        tick();
        rst = 1'b0;
        tick();
        chk("no_done_after_rst", 64'(n_done), 64'(base_done));
        start_frame(16'h0200, 2, 3, 0, 1'b0, PM_INTERN, DT_INT8);
        wait_done(cyc);
        chk("post_rst_done_cycle", 64'(cyc), 64'(6));
        after_done();
        // degenerate frame
        base_cmd = n_cmd;
        start_frame(16'h0300, 0, 3, 1, 1'b0, PM_INTERN, DT_INT8);
        chk("degen_no_cmd", 64'(rd_cmd.cmd_rd_en), 64'(0));
        wait_done(cyc);
        chk("degen_done_cycle", 64'(cyc), 64'(1));
        chk("degen_cmd_count", 64'(n_cmd), 64'(base_cmd));
        after_done();
        // start while busy is ignored
        base_cmd = n_cmd;
        start_frame(16'h0300, 1, 3, 0, 1'b0, PM_EXTERN, DT_INT16);
        cfg_base_addr = 16'h0999; cfg_h = 10'd5;
        start = 1'b1;
        tick();
        tick();
        start = 1'b0;
        wait_done(cyc);
        chk("b2b_done_cycle", 64'(cyc), 64'(1));
        chk("b2b_cmd_count", 64'(n_cmd - base_cmd), 64'(3));
        after_done();
        tick();
        chk("busy_stays_idle", 64'(busy), 64'(0));
        chk("queue_empty", 64'(q.size()), 64'(0));
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
